// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and the next-PC source select.
package cpu_pkg;

  localparam logic [7:0] OP_JUMP = 8'h06;
  localparam logic [7:0] OP_BEQ  = 8'h07;
  localparam logic [7:0] OP_BNE  = 8'h11;
  localparam logic [7:0] OP_CALL = 8'h12;
  localparam logic [7:0] OP_RET  = 8'h13;

  typedef enum logic [1:0] {
    SEQ,
    TGT,
    RAS
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module ras_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              ovf_pulse,
  output logic              unf_pulse
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem_reg [RAS_DEPTH];
  logic [PTR_W-1:0]  wp_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              full;
  logic [PTR_W-1:0]  top_idx;

  assign full      = (cnt_reg == CNT_W'(RAS_DEPTH));
  assign empty     = (cnt_reg == '0);
  assign top_idx   = wp_reg - PTR_W'(1);
  assign top       = mem_reg[top_idx];
  assign ovf_pulse = push & full;
  assign unf_pulse = pop & empty;

  // Pointer wraps naturally because RAS_DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp_reg  <= '0;
      cnt_reg <= '0;
    end else if (push) begin
      wp_reg <= wp_reg + PTR_W'(1);
      if (!full) cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      wp_reg  <= top_idx;
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_reg[wp_reg] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with relative branches/jumps, CALL/RET via a return-address stack,
// and stalling on instruction or data memory busy-wait.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_W    = 8,
  parameter int INSTR_BYTES = 4,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IBUSYWAIT,
  input  logic                DBUSYWAIT,
  input  logic                JMP,
  input  logic                BEQ,
  input  logic                BNE,
  input  logic                CALL,
  input  logic                RET,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   NXTPC,
  output logic                STALL,
  output logic                RAS_OVF,
  output logic                RAS_UNF
);

  localparam int SHIFT = $clog2(INSTR_BYTES);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] nxtpc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_ovf_pulse;
  logic              ras_unf_pulse;
  logic              advance;
  logic              ovf_reg;
  logic              unf_reg;
  pc_src_e           pc_src;

  assign nxtpc   = pc_reg + ADDR_W'(INSTR_BYTES);
  assign off_ext = ADDR_W'($signed(OFFSET));
  assign target  = nxtpc + (off_ext << SHIFT);
  assign STALL   = IBUSYWAIT | DBUSYWAIT;
  assign advance = ~STALL;

  // RET outranks CALL, so a simultaneous CALL+RET never pushes.
  assign ras_pop  = RET & advance;
  assign ras_push = CALL & ~RET & advance;

  always_comb begin
    pc_src = SEQ;
    if (RET)              pc_src = ras_empty ? SEQ : RAS;
    else if (CALL || JMP) pc_src = TGT;
    else if (BEQ)         pc_src = ZERO ? TGT : SEQ;
    else if (BNE)         pc_src = ZERO ? SEQ : TGT;
  end

  always_comb begin
    case (pc_src)
      TGT:     pc_next = target;
      RAS:     pc_next = ras_top;
      default: pc_next = nxtpc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_reg  <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else if (advance) begin
      pc_reg  <= pc_next;
      ovf_reg <= ovf_reg | ras_ovf_pulse;
      unf_reg <= unf_reg | ras_unf_pulse;
    end
  end

  ras_stack #(
    .RAS_DEPTH(RAS_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_ras (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(nxtpc),
    .top      (ras_top),
    .empty    (ras_empty),
    .ovf_pulse(ras_ovf_pulse),
    .unf_pulse(ras_unf_pulse)
  );

  assign PC      = pc_reg;
  assign NXTPC   = nxtpc;
  assign RAS_OVF = ovf_reg;
  assign RAS_UNF = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: a queue-based stack model predicts PC and flags; a negedge monitor checks them.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, IBUSYWAIT, DBUSYWAIT, JMP, BEQ, BNE, CALL, RET, ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] PC, NXTPC;
  logic        STALL, RAS_OVF, RAS_UNF;

  pc_sequencer #(
    .ADDR_W(32), .OFFSET_W(8), .INSTR_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .IBUSYWAIT(IBUSYWAIT), .DBUSYWAIT(DBUSYWAIT),
    .JMP(JMP), .BEQ(BEQ), .BNE(BNE), .CALL(CALL), .RET(RET), .ZERO(ZERO),
    .OFFSET(OFFSET), .PC(PC), .NXTPC(NXTPC), .STALL(STALL),
    .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        ovf;
    logic        unf;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ret_stack[$];
  logic [31:0] m_pc;
  logic        m_ovf, m_unf;
  int          checks = 0;
  int          passes = 0;
  int          txn    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Each cycle compares the state produced by the most recent rising edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("pc", PC, e.pc);
        check("nxtpc", NXTPC, e.pc + 32'd4);
        check("ras_ovf", {31'd0, RAS_OVF}, {31'd0, e.ovf});
        check("ras_unf", {31'd0, RAS_UNF}, {31'd0, e.unf});
        $display("txn %0d: PC=%h OVF=%0b UNF=%0b (expected %h %0b %0b)",
                 e.id, PC, RAS_OVF, RAS_UNF, e.pc, e.ovf, e.unf);
      end
    end
  end

  task automatic cyc(input logic rst, input logic ib, input logic db,
                     input logic j, input logic bq, input logic bn,
                     input logic c, input logic r, input logic z, input logic [7:0] off);
    logic [31:0] nxt, tgt;
    int          so;
    exp_t        e;
    RESET = rst; IBUSYWAIT = ib; DBUSYWAIT = db; JMP = j; BEQ = bq; BNE = bn;
    CALL = c; RET = r; ZERO = z; OFFSET = off;
    #1;
    check("stall", {31'd0, STALL}, {31'd0, ib | db});
    so  = $signed(off);
    nxt = m_pc + 32'd4;
    tgt = nxt + 32'(so * 4);
    if (rst) begin
      m_pc = 32'd0; m_ovf = 1'b0; m_unf = 1'b0;
      ret_stack.delete();
    end else if (!(ib || db)) begin
      if (r) begin
        if (ret_stack.size() > 0) m_pc = ret_stack.pop_back();
        else begin m_pc = nxt; m_unf = 1'b1; end
      end else if (c) begin
        ret_stack.push_back(nxt);
        if (ret_stack.size() > 4) begin
          void'(ret_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = tgt;
      end else if (j) m_pc = tgt;
      else if (bq)    m_pc = z ? tgt : nxt;
      else if (bn)    m_pc = z ? nxt : tgt;
      else            m_pc = nxt;
    end
    e.pc = m_pc; e.ovf = m_ovf; e.unf = m_unf; e.id = txn++;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(); cyc(0,0,0, 0,0,0, 0,0,0, 8'h00); endtask

  initial begin
    m_pc = 32'd0; m_ovf = 1'b0; m_unf = 1'b0;
    cyc(1,0,0, 0,0,0, 0,0,0, 8'h00);
    repeat (3) idle();
    // Reach 0x10, then JMP -2 and an untaken BEQ.
    cyc(1,0,0, 0,0,0, 0,0,0, 8'h00);
    cyc(0,0,0, 1,0,0, 0,0,0, 8'h03);
    cyc(0,0,0, 1,0,0, 0,0,0, 8'hFE);
    cyc(0,0,0, 0,1,0, 0,0,0, 8'h03);
    // From 0x20: CALL +4 then RET.
    cyc(0,0,0, 1,0,0, 0,0,0, 8'h03);
    cyc(0,0,0, 0,0,0, 1,0,0, 8'h04);
    cyc(0,0,0, 0,0,0, 0,1,0, 8'h00);
    // Five nested CALLs, five RETs.
    for (int i = 0; i < 5; i++) cyc(0,0,0, 0,0,0, 1,0,0, 8'(i + 1));
    for (int i = 0; i < 5; i++) cyc(0,0,0, 0,0,0, 0,1,0, 8'h00);
    // CALL held through a 3-cycle data stall, then released.
    cyc(1,0,0, 0,0,0, 0,0,0, 8'h00);
    repeat (3) cyc(0,0,1, 0,0,0, 1,0,0, 8'h05);
    cyc(0,0,0, 0,0,0, 1,0,0, 8'h05);
    cyc(0,0,0, 0,0,0, 0,1,0, 8'h00);
    cyc(0,0,0, 0,0,0, 0,1,0, 8'h00);
    // Wrap from 0xFFFF_FFFC, then reset during an instruction stall.
    cyc(1,0,0, 0,0,0, 0,0,0, 8'h00);
    cyc(0,0,0, 1,0,0, 0,0,0, 8'hFE);
    idle();
    cyc(0,0,0, 0,0,0, 1,0,0, 8'h10);
    cyc(1,1,0, 0,0,0, 0,0,0, 8'h00);
    cyc(0,0,0, 0,0,0, 0,1,0, 8'h00);
    // Simultaneous CALL+RET with a non-empty stack.
    cyc(0,0,0, 0,0,0, 1,0,0, 8'h07);
    cyc(0,0,0, 0,0,0, 1,1,0, 8'h09);
    cyc(0,0,0, 0,1,1, 0,0,0, 8'h02);
    // Randomized mix.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)));
    end
    idle();
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge CLK);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the single-cycle CPU. It replaces the separate PC register, PC+4 incrementer, branch-target adder and next-PC muxes with one block. It adds a small return-address stack (RAS) for CALL/RET and stalls on either memory busy-wait. It sits between the control unit (mode strobes), the ALU (ZERO flag) and the instruction memory (PC out).

## Interface
- ADDR_W, 32, PC width in bits
- OFFSET_W, 8, width of signed branch/jump offset from the instruction
- INSTR_BYTES, 4, bytes per instruction; power of two, ≥1
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2

- CLK  in  1  clock, rising edge
- RESET  in  1  reset: synchronous, active-high
- IBUSYWAIT  in  1  instruction memory busy; stalls the PC
- DBUSYWAIT  in  1  data memory busy; stalls the PC
- JMP  in  1  unconditional relative jump
- BEQ  in  1  branch if ZERO=1
- BNE  in  1  branch if ZERO=0
- CALL  in  1  push return address, jump relative
- RET  in  1  pop return address, jump to it
- ZERO  in  1  ALU zero flag for the current instruction
- OFFSET  in  OFFSET_W  signed instruction-count offset
- PC  out  ADDR_W  current PC (registered)
- NXTPC  out  ADDR_W  PC + INSTR_BYTES (combinational)
- STALL  out  1  IBUSYWAIT | DBUSYWAIT
- RAS_OVF  out  1  sticky: a push overwrote a live entry
- RAS_UNF  out  1  sticky: a pop occurred with the stack empty

## Operation
- NXTPC = PC + INSTR_BYTES, modulo 2^ADDR_W.
- TARGET = NXTPC + (sign_extend(OFFSET) << log2(INSTR_BYTES)), modulo 2^ADDR_W. Wrap-around is silent.
- Mode priority if several strobes are high: RET > CALL > JMP > BEQ > BNE. Lower strobes are ignored.
- Next PC:
  - RET: the top-of-stack value. If the stack is empty, use NXTPC and set RAS_UNF.
  - CALL: TARGET.
  - JMP: TARGET.
  - BEQ&ZERO: TARGET.
  - BNE&!ZERO: TARGET.
  - Otherwise: NXTPC.
- RAS is a circular buffer with write pointer wp and occupancy count cnt (0..RAS_DEPTH).
- CALL pushes NXTPC at wp, then wp++ and cnt = min(cnt+1, RAS_DEPTH).
  - A push when cnt==RAS_DEPTH overwrites the oldest entry and sets RAS_OVF.
- RET with cnt>0 pops entry wp-1, then wp-- and cnt--.
- RET with cnt==0 leaves wp and cnt unchanged.
- RAS_OVF and RAS_UNF stay set until RESET.

## Timing
- All state updates on the rising edge of CLK: PC, wp, cnt, RAS entries, flags.
- The RTL contains no explicit delays.
- Reset values: PC=0, wp=0, cnt=0, RAS_OVF=0, RAS_UNF=0. RAS entries are don't-care.
- NXTPC and STALL are combinational.
  - NXTPC = INSTR_BYTES in the cycle after reset.
  - STALL follows the busy inputs.
- Stall cycle (STALL=1 at the edge): PC, RAS, pointers and flags all hold. Strobes are re-evaluated on the first non-stalled edge.
- RESET takes precedence over stall and over every strobe, including reset asserted in the middle of a stall.
- Latency: the chosen next PC appears on PC one edge after the strobes are sampled. Zero-bubble back-to-back CALL/RET is supported.
- Simultaneous CALL+RET: RET wins. The stack does not push.

## Structure
Shared package `cpu_pkg`:
- Opcode constants 8'h06 (jump), 8'h07 (beq), 8'h11 (bne).
- New CALL/RET opcodes, reserved as 8'h12 and 8'h13.
- An enum for the next-PC source: SEQ, TGT, RAS.

One sub-module: `ras_stack`.
- Parameters: RAS_DEPTH, ADDR_W.
- Ports: push, pop, push data, top, empty, overflow/underflow event pulses.
- pc_sequencer holds the PC register, the adders, the priority mux and the sticky flags.

## Test plan
- Reset, then 3 idle cycles → PC = 0, 4, 8, 12. RAS_OVF=RAS_UNF=0.
- PC=0x10, JMP with OFFSET=8'hFE → next PC = 0x14 − 8 = 0x0C. BEQ with ZERO=0 and OFFSET=3 → PC = NXTPC, branch not taken.
- PC=0x20, CALL with OFFSET=4 → PC=0x34, RAS top=0x24. Next cycle RET → PC=0x24, cnt=0.
- Five nested CALLs with RAS_DEPTH=4 → RAS_OVF=1 after the fifth. Four RETs return the last four return addresses in LIFO order. A fifth RET → RAS_UNF=1 and PC=NXTPC.
- Stall: DBUSYWAIT=1 for 3 cycles while CALL is asserted → PC and cnt unchanged throughout. On release, exactly one push and PC=TARGET.
- PC=0xFFFF_FFFC, idle → PC wraps to 0. RESET asserted during IBUSYWAIT=1 → PC=0 and cnt=0 on that edge.
